// File: rtl/cacheline_adaptor_pkg.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor_pkg
// Shared types and constants for the cache-line to memory-burst adaptor.
//   adaptor_state_t : controller state (IDLE, READ, WRITE, DONE)
//   LINE_BYTES      : bytes per cache line
//   OFFSET_BITS     : address bits that select a byte within a line
//   BEATS           : memory-bus beats per line
//   line_align()    : clears the within-line offset bits of an address
// -----------------------------------------------------------------------------
package cacheline_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  localparam int LINE_BYTES  = 32;
  localparam int OFFSET_BITS = 5;
  localparam int BEATS       = 4;

  // The memory bus always transfers whole lines, so the byte offset is dropped.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor_if
// Bundles the cache-side (pmem_*) and memory-side (burst_*) signals of the
// adaptor.
//   modport slave  : the adaptor (responds to the cache, drives the burst bus)
//   modport master : the environment (cache initiator plus memory model)
// -----------------------------------------------------------------------------
interface cacheline_adaptor_if #(
  parameter int LINE_W = cacheline_adaptor_pkg::LINE_BYTES * 8,
  parameter int BEAT_W = cacheline_adaptor_pkg::LINE_BYTES * 8 / cacheline_adaptor_pkg::BEATS
);

  // Cache side
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // Memory side
  logic [31:0]       burst_address;
  logic              burst_read;
  logic              burst_write;
  logic [BEAT_W-1:0] burst_wdata;
  logic [BEAT_W-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  burst_rdata, burst_resp,
    output pmem_rdata, pmem_resp,
    output burst_address, burst_read, burst_write, burst_wdata
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    output burst_rdata, burst_resp,
    input  pmem_rdata, pmem_resp,
    input  burst_address, burst_read, burst_write, burst_wdata
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
// Converts one cache-line read or write request into a burst of beats on the
// main-memory bus and returns a single-cycle completion pulse to the cache.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : cacheline_adaptor_if.slave
//          pmem_address/read/write/wdata in, pmem_rdata/resp out,
//          burst_address/read/write/wdata out, burst_rdata/resp in
// -----------------------------------------------------------------------------
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W = LINE_BYTES * 8,
  parameter int BEAT_W = LINE_BYTES * 8 / BEATS
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
);

  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  adaptor_state_t    state_q, state_d;
  logic [31:0]       addr_q,  addr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // The read line lives in its own register so a later write leaves it intact.
  assign bus.pmem_rdata = rdata_q;

  // State, latched request and beat counter; reset discards any partial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wline_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode. Bus controls depend only on the registered
  // state, so the cache and memory never see a combinational path through here.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    wline_d           = wline_q;
    rdata_d           = rdata_q;
    cnt_d             = cnt_q;
    bus.burst_address = '0;
    bus.burst_read    = 1'b0;
    bus.burst_write   = 1'b0;
    bus.burst_wdata   = '0;
    bus.pmem_resp     = 1'b0;

    case (state_q)
      IDLE: begin
        // Read wins if the cache ever raises both requests.
        if (bus.pmem_read) begin
          addr_d  = bus.pmem_address;
          cnt_d   = '0;
          state_d = READ;
        end else if (bus.pmem_write) begin
          addr_d  = bus.pmem_address;
          wline_d = bus.pmem_wdata;
          cnt_d   = '0;
          state_d = WRITE;
        end
      end

      READ: begin
        bus.burst_read    = 1'b1;
        bus.burst_address = line_align(addr_q);
        if (bus.burst_resp) begin
          for (int b = 0; b < NBEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
              rdata_d[b*BEAT_W +: BEAT_W] = bus.burst_rdata;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end

      WRITE: begin
        bus.burst_write   = 1'b1;
        bus.burst_address = line_align(addr_q);
        // Current beat stays on the bus through any gaps in burst_resp.
        for (int b = 0; b < NBEATS; b++) begin
          if (cnt_q == CNT_W'(b)) begin
            bus.burst_wdata = wline_q[b*BEAT_W +: BEAT_W];
          end
        end
        if (bus.burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // The request is still high here; returning unconditionally to IDLE
        // gives the cache this cycle to drop it.
        bus.pmem_resp = 1'b1;
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
// Self-checking bench for cacheline_adaptor. The bench plays both the cache
// and the memory: each line is a 256-bit value whose k-th 64-bit beat is
// (line >> 64*k), so the expected assembled line is simply the line itself.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst;

  int checkCount = 0;
  int errorCount = 0;

  // What pmem_rdata should show: the most recent completed read line.
  logic [255:0] lastReadLine = '0;

  cacheline_adaptor_if #(.LINE_W(256), .BEAT_W(64)) bus ();

  cacheline_adaptor #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // The cache model must never raise both requests together.
  always @(negedge clk) begin
    if (!rst && bus.pmem_read === 1'b1 && bus.pmem_write === 1'b1) begin
      errorCount++;
      $display("[TB] FAIL illegal_stim: pmem_read and pmem_write both high at %0t", $time);
    end
  end

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] random_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Full read transaction. pat bit i gives burst_resp in the i-th READ cycle
  // (1 once past bit 31). Checks protocol every cycle and the result at DONE.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] line,
                          input logic [31:0] pat, input string tag);
    int k;
    int cyc;
    logic resp;
    logic [31:0] expAddr;
    expAddr = addr & 32'hFFFF_FFE0;

    bus.pmem_address = addr;
    bus.pmem_read    = 1'b1;
    checkCount++;
    if (bus.burst_read !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL %s_cycle0_read: got %b expected 0", tag, bus.burst_read);
    end
    tick();

    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 64) begin
      resp = (cyc < 32) ? pat[cyc] : 1'b1;
      bus.burst_resp  = resp;
      bus.burst_rdata = resp ? 64'(line >> (64 * k)) : {$urandom, $urandom};
      checkCount++;
      if (bus.burst_read !== 1'b1 || bus.burst_write !== 1'b0 || bus.burst_address !== expAddr) begin
        errorCount++;
        $display("[TB] FAIL %s_burst_req: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=%h",
                 tag, bus.burst_read, bus.burst_write, bus.burst_address, expAddr);
      end
      checkCount++;
      if (bus.pmem_resp !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL %s_early_resp: got %b expected 0 (cycle %0d)", tag, bus.pmem_resp, cyc);
      end
      tick();
      if (resp) k++;
      cyc++;
    end
    bus.burst_resp = 1'b0;
    checkCount++;
    if (k < 4) begin
      errorCount++;
      $display("[TB] FAIL %s_timeout: got %0d beats expected 4", tag, k);
    end

    // DONE cycle: request still held, a stray burst_resp must be ignored.
    bus.burst_resp  = 1'b1;
    bus.burst_rdata = {$urandom, $urandom};
    checkCount++;
    if (bus.pmem_resp !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL %s_resp: got %b expected 1", tag, bus.pmem_resp);
    end
    checkCount++;
    if (bus.pmem_rdata !== line) begin
      errorCount++;
      $display("[TB] FAIL %s_rdata: got %h expected %h", tag, bus.pmem_rdata, line);
    end
    checkCount++;
    if (bus.burst_read !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL %s_done_read: got %b expected 0", tag, bus.burst_read);
    end
    lastReadLine  = line;
    bus.pmem_read = 1'b0;
    tick();

    bus.burst_resp = 1'b0;
    checkCount++;
    if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b0 || bus.pmem_rdata !== line) begin
      errorCount++;
      $display("[TB] FAIL %s_after: got resp=%b rd=%b rdata=%h expected resp=0 rd=0 rdata=%h",
               tag, bus.pmem_resp, bus.burst_read, bus.pmem_rdata, line);
    end
  endtask

  // Full write transaction; pmem_wdata is scrambled after cycle 0 so only the
  // latched copy can produce the right beats.
  task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [31:0] pat, input string tag);
    int k;
    int cyc;
    logic resp;
    logic [31:0] expAddr;
    logic [63:0] expBeat;
    expAddr = addr & 32'hFFFF_FFE0;

    bus.pmem_address = addr;
    bus.pmem_wdata   = line;
    bus.pmem_write   = 1'b1;
    checkCount++;
    if (bus.burst_write !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL %s_cycle0_write: got %b expected 0", tag, bus.burst_write);
    end
    tick();
    bus.pmem_wdata = random_line();

    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 64) begin
      resp = (cyc < 32) ? pat[cyc] : 1'b1;
      bus.burst_resp  = resp;
      bus.burst_rdata = {$urandom, $urandom};
      expBeat = 64'(line >> (64 * k));
      checkCount++;
      if (bus.burst_write !== 1'b1 || bus.burst_read !== 1'b0 || bus.burst_address !== expAddr) begin
        errorCount++;
        $display("[TB] FAIL %s_burst_req: got wr=%b rd=%b addr=%h expected wr=1 rd=0 addr=%h",
                 tag, bus.burst_write, bus.burst_read, bus.burst_address, expAddr);
      end
      checkCount++;
      if (bus.burst_wdata !== expBeat) begin
        errorCount++;
        $display("[TB] FAIL %s_wdata: got %h expected %h (beat %0d)", tag, bus.burst_wdata, expBeat, k);
      end
      checkCount++;
      if (bus.pmem_rdata !== lastReadLine || bus.pmem_resp !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL %s_hold: got rdata=%h resp=%b expected rdata=%h resp=0",
                 tag, bus.pmem_rdata, bus.pmem_resp, lastReadLine);
      end
      tick();
      if (resp) k++;
      cyc++;
    end
    bus.burst_resp = 1'b0;
    checkCount++;
    if (k < 4) begin
      errorCount++;
      $display("[TB] FAIL %s_timeout: got %0d beats expected 4", tag, k);
    end

    checkCount++;
    if (bus.pmem_resp !== 1'b1 || bus.burst_write !== 1'b0 || bus.pmem_rdata !== lastReadLine) begin
      errorCount++;
      $display("[TB] FAIL %s_done: got resp=%b wr=%b rdata=%h expected resp=1 wr=0 rdata=%h",
               tag, bus.pmem_resp, bus.burst_write, bus.pmem_rdata, lastReadLine);
    end
    bus.pmem_write = 1'b0;
    tick();

    checkCount++;
    if (bus.pmem_resp !== 1'b0 || bus.burst_write !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL %s_after: got resp=%b wr=%b expected 0 0", tag, bus.pmem_resp, bus.burst_write);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checkCount++;
    if (bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0 || bus.pmem_resp !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_ctrl: got rd=%b wr=%b resp=%b expected 0 0 0",
               bus.burst_read, bus.burst_write, bus.pmem_resp);
    end
    checkCount++;
    if (bus.burst_address !== 32'h0 || bus.burst_wdata !== 64'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_bus: got addr=%h wdata=%h expected 0 0", bus.burst_address, bus.burst_wdata);
    end
    checkCount++;
    if (bus.pmem_rdata !== 256'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_rdata: got %h expected 0", bus.pmem_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    run_read(32'h1234_5678,
             {64'h0000_0000_0000_000D, 64'h0000_0000_0000_000C,
              64'h0000_0000_0000_000B, 64'h0000_0000_0000_000A},
             32'hFFFF_FFFF, "read_basic");
  endtask

  // Follows a read, so pmem_rdata must keep that line throughout.
  task automatic test_write_basic();
    run_write(32'h0000_0040,
              {64'h4, 64'h3, 64'h2, 64'h1},
              32'hFFFF_FFFF, "write_basic");
  endtask

  task automatic test_read_gaps();
    // burst_resp pattern 1,0,0,1,1,0,1 (LSB first)
    run_read(32'h8000_0023, random_line(), 32'h0000_0059, "read_gaps");
  endtask

  task automatic test_back_to_back();
    run_read(32'hA000_0000, random_line(), 32'hFFFF_FFFF, "b2b_first");
    run_read(32'hA000_0020, random_line(), 32'hFFFF_FFFF, "b2b_second");
  endtask

  task automatic test_reset_midburst();
    bus.pmem_address = 32'h0000_1000;
    bus.pmem_read    = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = {$urandom, $urandom};
      tick();
    end
    rst = 1'b1;
    #1;
    checkCount++;
    if (bus.burst_read !== 1'b0 || bus.burst_address !== 32'h0 || bus.pmem_resp !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL midrst_ctrl: got rd=%b addr=%h resp=%b expected 0 0 0",
               bus.burst_read, bus.burst_address, bus.pmem_resp);
    end
    checkCount++;
    if (bus.pmem_rdata !== 256'h0) begin
      errorCount++;
      $display("[TB] FAIL midrst_rdata: got %h expected 0", bus.pmem_rdata);
    end
    lastReadLine   = '0;
    bus.pmem_read  = 1'b0;
    bus.burst_resp = 1'b0;
    tick();
    tick();
    checkCount++;
    if (bus.pmem_resp !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL midrst_noresp: got %b expected 0", bus.pmem_resp);
    end
    rst = 1'b0;
    tick();
    run_read(32'h0000_2000, random_line(), 32'hFFFF_FFFF, "midrst_fresh");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1)
        run_read($urandom, random_line(), $urandom, "rand_read");
      else
        run_write($urandom, random_line(), $urandom, "rand_write");
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.pmem_address = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;

    test_reset();
    test_read_basic();
    test_write_basic();
    test_read_gaps();
    test_back_to_back();
    test_reset_midburst();
    test_random();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
